// File: rtl/uart_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uart_ctrl_pkg
// Shared types and constants for the UART transmit-side control blocks.
//   BYTE_W  : width of one transmitted byte
//   ID_W    : width of a requester index (covers up to 8 requesters)
//   state_t : arbiter FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
// ---------------------------------------------------------------------------
package uart_ctrl_pkg;

  localparam int BYTE_W = 8;
  localparam int ID_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage : uart_ctrl_pkg

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts one past
// last_grant and wraps modulo NUM_REQ; the first asserted request wins.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  ID_W     index served most recently
//   valid      out 1        at least one request is asserted
//   index      out ID_W     winning requester (0 when valid is low)
// ---------------------------------------------------------------------------
module rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic               valid,
  output logic [ID_W-1:0]    index
);

  // Zero-extended copy so a full ID_W-bit index can address it directly.
  logic [(1 << ID_W)-1:0] req_ext;
  logic [ID_W:0]          sum;
  logic [ID_W-1:0]        cand;

  assign req_ext = (1 << ID_W)'(req);

  // Walk from the farthest candidate to the nearest one; the last hit
  // written is the nearest to last_grant, i.e. the highest priority.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    valid = 1'b0;
    index = '0;
    sum   = '0;
    cand  = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      sum = {1'b0, last_grant} + (ID_W + 1)'(off);
      // last_grant < NUM_REQ and off <= NUM_REQ, so one subtraction wraps.
      if (sum >= (ID_W + 1)'(NUM_REQ)) begin
        sum = sum - (ID_W + 1)'(NUM_REQ);
      end
      cand = sum[ID_W-1:0];
      if (req_ext[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ byte requesters using
// round-robin priority. A grant latches the requester's byte, strobes
// senddata for one cycle, then waits for txdone and acks the requester.
//
// Optional feature (macro UART_ARB_TIMEOUT_EN): a WAIT-state watchdog that
// aborts a transfer after TIMEOUT_CYCLES cycles without txdone, pulsing
// timeout instead of ack. Without the macro the arbiter waits forever.
//
// Ports:
//   clk       in  1            clock, all logic on posedge
//   rst       in  1            synchronous active-high reset
//   req       in  NUM_REQ      per-requester send request
//   req_data  in  8*NUM_REQ    byte i at [8i+7:8i]
//   ack       out NUM_REQ      one-cycle completion pulse to the granted requester
//   busy      out 1            FSM not in IDLE
//   grant_id  out 3            current / last granted requester
//   senddata  out 1            start strobe to the UART transmitter
//   txbyte    out 8            byte to the UART transmitter
//   txdone    in  1            completion pulse from the UART transmitter
//   timeout   out 1            one-cycle pulse on watchdog abort
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      senddata,
  output logic [BYTE_W-1:0]         txbyte,
  input  logic                      txdone,
  output logic                      timeout
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  state_t              state_q, state_d;
  logic [ID_W-1:0]     grant_id_q;
  logic [ID_W-1:0]     last_grant_q;
  logic [BYTE_W-1:0]   txbyte_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic                timeout_q;

  logic                arb_valid;
  logic [ID_W-1:0]     arb_idx;
  logic [BYTE_W-1:0]   sel_byte;

  logic                load_grant;
  logic                finish_ok;
  logic                finish_abort;
  logic                wd_expire;

  // -------------------------------------------------------------------------
  // Round-robin pick
  // -------------------------------------------------------------------------
  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req        (req),
    .last_grant (last_grant_q),
    .valid      (arb_valid),
    .index      (arb_idx)
  );

  // Byte of the winning requester; constant slices keep the mux simple.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == ID_W'(i)) begin
        sel_byte = req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // -------------------------------------------------------------------------
  // WAIT-state watchdog
  // -------------------------------------------------------------------------
`ifdef UART_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt_q;

  // Cleared while in ISSUE so the count restarts on every WAIT entry; the
  // FSM leaves WAIT at TIMEOUT_CYCLES-1, so the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      wd_cnt_q <= '0;
    end else if (state_q == WAIT) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  assign wd_expire = (state_q == WAIT) && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expire = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: reset is synchronous: it is sampled at the clock edge inside the
  // block and does not appear in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_valid)            state_d = ISSUE;
      ISSUE:                             state_d = WAIT;
      WAIT:    if (txdone || wd_expire)  state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs and datapath strobes
  // -------------------------------------------------------------------------
  // txdone only matters in WAIT; when it coincides with watchdog expiry the
  // transfer completes normally.
  always_comb begin
    senddata     = (state_q == ISSUE);
    busy         = (state_q != IDLE);
    load_grant   = (state_q == IDLE) && arb_valid;
    finish_ok    = (state_q == WAIT) && txdone;
    finish_abort = (state_q == WAIT) && !txdone && wd_expire;
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  // last_grant resets to NUM_REQ-1 so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      txbyte_q     <= '0;
      ack_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      ack_q     <= finish_ok ? (NUM_REQ'(1) << grant_id_q) : '0;
      timeout_q <= finish_abort;
      if (load_grant) begin
        grant_id_q <= arb_idx;
        txbyte_q   <= sel_byte;
      end
      // An aborted transfer still advances priority past the stuck requester.
      if (finish_ok || finish_abort) begin
        last_grant_q <= grant_id_q;
      end
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_id_q;
  assign txbyte   = txbyte_q;
  assign timeout  = timeout_q;

endmodule : uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, WAIT-state watchdog limit (active only with UART_ARB_TIMEOUT_EN).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester send request.
- req_data  in  8*NUM_REQ  byte i at bits [8i+7:8i].
- ack  out  NUM_REQ  one-cycle pulse to requester i when its byte completes.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  3  index of the current or last granted requester.
- senddata  out  1  start strobe to the UART transmitter.
- txbyte  out  8  byte to the UART transmitter.
- txdone  in  1  one-cycle completion pulse from the UART transmitter.
- timeout  out  1  one-cycle pulse on watchdog abort.

Function
REQ-005 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE.
REQ-006 SHALL, in IDLE with any req bit high, grant the highest-priority requester, latch its req_data into txbyte, update grant_id, and enter ISSUE in the same clock edge.
REQ-007 SHALL use round-robin priority: search starts at (last grant + 1) mod NUM_REQ and wraps; after reset, requester 0 has highest priority.
REQ-008 SHALL assert senddata for exactly one cycle, in ISSUE only, then enter WAIT.
REQ-009 SHALL hold txbyte stable from grant until the next grant.
REQ-010 SHALL, in WAIT on txdone=1, pulse ack[grant_id] for one cycle, record grant_id as last grant, and return to IDLE.
REQ-011 SHALL ignore txdone outside WAIT.
REQ-012 SHALL insert at least one IDLE cycle between back-to-back bytes, so senddata is never high in the cycle after txdone.
REQ-013 SHALL fix the requester contract as: hold req and req_data until ack.
REQ-014 SHALL still send and ack a granted byte if req drops after grant.
REQ-015 SHALL not let req changes of non-granted requesters affect an in-flight transfer.
REQ-016 SHALL, with NUM_REQ requests continuously high, serve each requester exactly once per NUM_REQ transfers.
REQ-017 SHALL make ack one-hot or zero; timeout and ack are never high together.

Reset
REQ-018 SHALL, on rst=1 at a clock edge, set: state IDLE, senddata 0, txbyte 0, ack 0, busy 0, grant_id 0, timeout 0, last grant NUM_REQ-1, watchdog counter 0.
REQ-019 SHALL abandon an in-flight transfer on reset mid-operation (ISSUE/WAIT) without an ack; a later stray txdone is ignored per REQ-011.

Configuration
REQ-020 SHALL use macro UART_ARB_TIMEOUT_EN.
REQ-021 SHALL, with UART_ARB_TIMEOUT_EN defined:
- count cycles in WAIT.
- if TIMEOUT_CYCLES cycles elapse without txdone, pulse timeout, issue no ack, advance last grant to grant_id, and return to IDLE.
- reset the counter on WAIT entry.
- let txdone win if it arrives in the same cycle the count expires.
REQ-022 SHALL, without UART_ARB_TIMEOUT_EN, include no counter logic, tie timeout to 0, and wait in WAIT indefinitely.

Structure
REQ-023 SHALL place the FSM state enum (IDLE, ISSUE, WAIT) and the byte-width constant (8) in shared package uart_ctrl_pkg.
REQ-024 SHALL contain one sub-module, rr_arbiter: combinational round-robin pick of req and last grant -> valid and index.

Verification
REQ-025 SHALL cover: reset, then req=0001, data0=0x55, txdone 11 cycles after senddata -> senddata 1-cycle with txbyte=0x55, ack=0001 one cycle after txdone, busy low next cycle.
REQ-026 SHALL cover: req=1111 held, data i=0x10+i -> txbyte sequence 0x10,0x11,0x12,0x13,0x10; ack order 0,1,2,3,0.
REQ-027 SHALL cover: req0 and req2 held after requester 0 served -> next grant_id=2, then 0.
REQ-028 SHALL cover: rst pulsed during WAIT, then txdone -> no ack; next grant goes to requester 0.
REQ-029 SHALL cover: with UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, txdone never returned -> timeout pulse 8 cycles after WAIT entry, ack=0, next requester granted; without the macro, busy stays high.
REQ-030 SHALL cover: txdone pulsed while IDLE -> no ack, state unchanged.
